// File: rtl/jesd204_rx_cgs_lane_pkg.sv
// Shared JESD204 RX constants: CGS state encodings, the K28.5 comma value and
// counter widths used by the lane synchroniser.
package jesd204_rx_cgs_lane_pkg;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  localparam logic [7:0] K28_5 = 8'hBC;

  localparam int ERR_CNT_W    = 3;
  localparam int K_CNT_W      = 4;
  localparam int STATUS_CNT_W = 8;

endpackage

// File: rtl/jesd204_rx_cgs_char_check.sv
// Classifies one received octet: a clean K28.5 comma, or a coding error.
module jesd204_rx_cgs_char_check
  import jesd204_rx_cgs_lane_pkg::*;
(
  input  logic [7:0] data,
  input  logic       charisk,
  input  logic       disperr,
  input  logic       notintable,
  output logic       k_ok,
  output logic       err
);

  assign err  = disperr | notintable;
  assign k_ok = charisk & (data == K28_5) & ~err;

endmodule

// File: rtl/jesd204_rx_cgs_lane.sv
// Per-lane JESD204 code group synchronisation: hunts for K28.5 beats, then
// tracks coding errors with a leaky error counter until sync is lost.
module jesd204_rx_cgs_lane
  import jesd204_rx_cgs_lane_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 4,
  parameter int K_BEATS_LIMIT   = 4,
  parameter int ERR_LIMIT       = 3
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         cgs_reset,
  input  logic [8*DATA_PATH_WIDTH-1:0] phy_data,
  input  logic [DATA_PATH_WIDTH-1:0]   phy_charisk,
  input  logic [DATA_PATH_WIDTH-1:0]   phy_disperr,
  input  logic [DATA_PATH_WIDTH-1:0]   phy_notintable,
  output logic                         ready,
  output logic [1:0]                   status_state,
  output logic [7:0]                   status_err_cnt,
  output logic                         event_sync_lost
);

  localparam logic [K_CNT_W-1:0]   K_LAST   = K_CNT_W'(K_BEATS_LIMIT - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_LAST = ERR_CNT_W'(ERR_LIMIT - 1);

  logic [DATA_PATH_WIDTH-1:0] k_ok_vec;
  logic [DATA_PATH_WIDTH-1:0] err_vec;
  logic                       beat_all_k;
  logic                       beat_err;

  logic [1:0]              state;
  logic [K_CNT_W-1:0]      k_cnt;
  logic [ERR_CNT_W-1:0]    err_cnt;
  logic [STATUS_CNT_W-1:0] err_total;

  for (genvar i = 0; i < DATA_PATH_WIDTH; i++) begin : g_octet
    jesd204_rx_cgs_char_check u_char_check (
      .data       (phy_data[8*i +: 8]),
      .charisk    (phy_charisk[i]),
      .disperr    (phy_disperr[i]),
      .notintable (phy_notintable[i]),
      .k_ok       (k_ok_vec[i]),
      .err        (err_vec[i])
    );
  end

  assign beat_all_k = &k_ok_vec;
  assign beat_err   = |err_vec;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk) begin
    if (!resetn || cgs_reset) begin
      state           <= ST_INIT;
      k_cnt           <= '0;
      err_cnt         <= '0;
      err_total       <= '0;
      event_sync_lost <= 1'b0;
    end else begin
      event_sync_lost <= 1'b0;

      if (beat_err && err_total != '1) begin
        err_total <= err_total + 1'b1;
      end

      case (state)
        ST_INIT: begin
          err_cnt <= '0;
          if (!beat_all_k) begin
            k_cnt <= '0;
          end else if (k_cnt == K_LAST) begin
            state <= ST_CHECK;
            k_cnt <= '0;
          end else begin
            k_cnt <= k_cnt + 1'b1;
          end
        end

        ST_CHECK, ST_DATA: begin
          k_cnt <= '0;
          if (beat_err) begin
            // An error beat never advances CHECK to DATA, even below the limit.
            if (err_cnt == ERR_LAST) begin
              state           <= ST_INIT;
              err_cnt         <= '0;
              event_sync_lost <= 1'b1;
            end else begin
              err_cnt <= err_cnt + 1'b1;
            end
          end else begin
            if (err_cnt != '0) begin
              err_cnt <= err_cnt - 1'b1;
            end
            if (state == ST_CHECK && !beat_all_k) begin
              state <= ST_DATA;
            end
          end
        end

        default: begin
          state   <= ST_INIT;
          k_cnt   <= '0;
          err_cnt <= '0;
        end
      endcase
    end
  end

  assign ready          = (state == ST_CHECK) || (state == ST_DATA);
  assign status_state   = state;
  assign status_err_cnt = err_total;

endmodule
